// File: rtl/cell_draw_if.sv
// Tracker-event and 8080 write-bus signals of the cell draw engine.
// master = tracker/panel side, slave = the engine.
interface cell_draw_if;
  logic       init_done;
  logic       diff;
  logic [3:0] x;
  logic [3:0] y;
  logic [2:0] obj_code;
  logic       scan_en;
  logic       lcd_csx;
  logic       lcd_dcx;
  logic       lcd_wrx;
  logic [7:0] lcd_d;
  logic       busy;
  logic       overflow;

  modport master (
    output init_done, diff, x, y, obj_code,
    input  scan_en, lcd_csx, lcd_dcx, lcd_wrx, lcd_d, busy, overflow
  );

  modport slave (
    input  init_done, diff, x, y, obj_code,
    output scan_en, lcd_csx, lcd_dcx, lcd_wrx, lcd_d, busy, overflow
  );
endinterface

// File: rtl/cell_draw_engine.sv
// Buffers cell-change events and repaints each changed cell as a solid
// CELL_PX x CELL_PX RGB565 block over an 8080-style 8-bit write bus.
module cell_draw_engine #(
  parameter int unsigned CELL_PX    = 20,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic       clk,
  input logic       nrst,
  cell_draw_if.slave bus
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PIX_BYTES = 2 * CELL_PX * CELL_PX;
  localparam int unsigned PIX_W     = $clog2(PIX_BYTES);

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] obj;
  } cell_evt_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CASET_C, S_CASET_D, S_PASET_C, S_PASET_D, S_RAMWR_C, S_PIXELS
  } state_t;

  state_t           state_q, state_d;
  logic             phase_q, phase_d;
  logic [PIX_W-1:0] cnt_q, cnt_d;
  cell_evt_t        fifo_q [FIFO_DEPTH];
  cell_evt_t        fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  cell_evt_t        cur_q, cur_d;
  logic             csx_q, csx_d, dcx_q, dcx_d, wrx_q, wrx_d;
  logic [7:0]       d_q, d_d;
  logic             busy_q, busy_d, overflow_q, overflow_d, scan_en_q, scan_en_d;

  logic             full_c, push_c, pop_c, last_c;
  logic [15:0]      lo_c, hi_c, colour_c;
  logic [7:0]       byte_c;

  function automatic logic [7:0] word_byte(input logic [15:0] first_w,
                                           input logic [15:0] second_w,
                                           input logic [1:0]  sel);
    case (sel)
      2'd0:    return first_w[15:8];
      2'd1:    return first_w[7:0];
      2'd2:    return second_w[15:8];
      default: return second_w[7:0];
    endcase
  endfunction

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cur_d      = cur_q;
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    lo_c       = 16'h0000;
    hi_c       = 16'h0000;
    colour_c   = 16'h0000;
    byte_c     = 8'h00;

    // Full is taken from the registered count: a same-cycle pop never frees a slot.
    full_c = (count_q == CNT_W'(FIFO_DEPTH));
    push_c = bus.diff && !full_c && (bus.y <= 4'd11);
    pop_c  = (state_q == S_IDLE) && (count_q != '0) && bus.init_done;

    if (push_c) begin
      fifo_d[wr_ptr_q] = '{x: bus.x, y: bus.y, obj: bus.obj_code};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      cur_d    = fifo_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_CASET_D, S_PASET_D: last_c = (cnt_q == PIX_W'(3));
      S_PIXELS:             last_c = (cnt_q == PIX_W'(PIX_BYTES - 1));
      default:              last_c = 1'b1;
    endcase

    // Byte sequencer: two cycles per byte, advance position after phase 1.
    if (state_q == S_IDLE) begin
      if (pop_c) begin
        state_d = S_CASET_C;
        phase_d = 1'b0;
        cnt_d   = '0;
      end
    end else if (!phase_q) begin
      phase_d = 1'b1;
    end else begin
      phase_d = 1'b0;
      if (last_c) begin
        cnt_d = '0;
        case (state_q)
          S_CASET_C: state_d = S_CASET_D;
          S_CASET_D: state_d = S_PASET_C;
          S_PASET_C: state_d = S_PASET_D;
          S_PASET_D: state_d = S_RAMWR_C;
          S_RAMWR_C: state_d = S_PIXELS;
          default:   state_d = S_IDLE;
        endcase
      end else begin
        cnt_d = cnt_q + PIX_W'(1);
      end
    end

    case (cur_q.obj)
      3'd1:    colour_c = 16'h07E0;
      3'd2:    colour_c = 16'hFFE0;
      3'd3:    colour_c = 16'hF800;
      3'd4:    colour_c = 16'hFFFF;
      default: colour_c = 16'h0000;
    endcase

    if (state_d == S_PASET_D) begin
      lo_c = 16'(cur_q.y) * 16'(CELL_PX);
    end else begin
      lo_c = 16'(cur_q.x) * 16'(CELL_PX);
    end
    hi_c = lo_c + 16'(CELL_PX - 1);

    // Outputs are registered from the position the bus will hold next cycle.
    case (state_d)
      S_CASET_C:            byte_c = 8'h2A;
      S_PASET_C:            byte_c = 8'h2B;
      S_RAMWR_C:            byte_c = 8'h2C;
      S_CASET_D, S_PASET_D: byte_c = word_byte(lo_c, hi_c, cnt_d[1:0]);
      S_PIXELS:             byte_c = cnt_d[0] ? colour_c[7:0] : colour_c[15:8];
      default:              byte_c = 8'h00;
    endcase

    csx_d      = (state_d == S_IDLE);
    wrx_d      = (state_d == S_IDLE) || phase_d;
    dcx_d      = !((state_d == S_CASET_C) || (state_d == S_PASET_C) ||
                   (state_d == S_RAMWR_C));
    d_d        = byte_c;
    busy_d     = (count_d != '0) || (state_d != S_IDLE);
    scan_en_d  = (count_d != CNT_W'(FIFO_DEPTH));
    overflow_d = overflow_q || (bus.diff && full_c);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cur_q      <= '0;
      csx_q      <= 1'b1;
      dcx_q      <= 1'b1;
      wrx_q      <= 1'b1;
      d_q        <= 8'h00;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      scan_en_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cur_q      <= cur_d;
      csx_q      <= csx_d;
      dcx_q      <= dcx_d;
      wrx_q      <= wrx_d;
      d_q        <= d_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      scan_en_q  <= scan_en_d;
    end
  end

  assign bus.lcd_csx  = csx_q;
  assign bus.lcd_dcx  = dcx_q;
  assign bus.lcd_wrx  = wrx_q;
  assign bus.lcd_d    = d_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;
  assign bus.scan_en  = scan_en_q;

endmodule
